// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared types for the cycle-counter monitor.
//   CNT_WIDTH : counter width shared with the upstream free-running counter
//   state_e   : monitor FSM state (IDLE/TRACK/DONE)
//   evt_t     : mismatch event {expected, actual}
package count_mon_pkg;

  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] expected;
    logic [CNT_WIDTH-1:0] actual;
  } evt_t;

endpackage

// File: rtl/count_mon_fifo.sv
// count_mon_fifo: DEPTH x evt_t first-word-fall-through event buffer.
//   clk, reset_n : clock, synchronous active-low reset (empties the buffer)
//   push, data_in: write request and event; dropped when full without a pop
//   pop          : consume head (ignored while empty)
//   data_out     : head entry, read straight from storage registers
//   valid        : buffer non-empty
//   drop         : pulse for a push lost to a full buffer
module count_mon_fifo
  import count_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  evt_t data_in,
  input  logic pop,
  output evt_t data_out,
  output logic valid,
  output logic drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    valid   = (count != '0);
    do_pop  = pop && valid;
    // A pop frees the slot being written when full, so the push is accepted.
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks that an upstream counter starts at 0 and increments
// by one up to END_COUNT, logging each mismatch as an {expected, actual} event.
//   clk, reset_n    : clock, synchronous active-low reset
//   cnt_valid_i     : upstream counter out of reset
//   cnt_i           : upstream counter value
//   evt_valid_o     : event available at buffer head
//   evt_ready_i     : consumer accepts head event
//   evt_expected_o  : head event expected value
//   evt_actual_o    : head event observed value
//   state_o         : IDLE=0, TRACK=1, DONE=2
//   done_o, pass_o  : run complete / complete with no errors and no drops
//   err_count_o     : saturating mismatch count
//   drop_count_o    : saturating count of events lost to a full buffer
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = CNT_WIDTH,
  parameter int unsigned END_COUNT  = 99,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cnt_valid_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] evt_expected_o,
  output logic [WIDTH-1:0] evt_actual_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [7:0]       drop_count_o
);

  state_e           state;
  logic [WIDTH-1:0] expected;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       drop_count;

  logic             sample;
  logic             mism;
  logic             at_end;
  logic [WIDTH-1:0] chk_exp;
  evt_t             push_evt;
  evt_t             head;
  logic             fifo_valid;
  logic             fifo_drop;

  always_comb begin
    sample            = cnt_valid_i && (state != DONE);
    chk_exp           = (state == IDLE) ? '0 : expected;
    mism              = sample && (cnt_i != chk_exp);
    at_end            = (cnt_i == WIDTH'(END_COUNT));
    push_evt.expected = chk_exp;
    push_evt.actual   = cnt_i;
  end

  count_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (mism),
    .data_in  (push_evt),
    .pop      (evt_ready_i),
    .data_out (head),
    .valid    (fifo_valid),
    .drop     (fifo_drop)
  );

  // On a match cnt_i equals expected, so cnt_i+1 covers both the match
  // increment and the mismatch resync.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      expected   <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt_valid_i) begin
            expected <= cnt_i + WIDTH'(1);
            state    <= at_end ? DONE : TRACK;
          end
        end
        TRACK: begin
          if (!cnt_valid_i) begin
            expected <= '0;
            state    <= IDLE;
          end else begin
            expected <= cnt_i + WIDTH'(1);
            if (at_end) state <= DONE;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
      if (mism && (err_count != '1))      err_count  <= err_count + ERR_W'(1);
      if (fifo_drop && (drop_count != '1)) drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    state_o        = state;
    done_o         = (state == DONE);
    pass_o         = done_o && (err_count == '0) && (drop_count == '0);
    err_count_o    = err_count;
    drop_count_o   = drop_count;
    evt_valid_o    = fifo_valid;
    evt_expected_o = fifo_valid ? head.expected : '0;
    evt_actual_o   = fifo_valid ? head.actual   : '0;
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor
// (END_COUNT=99, FIFO_DEPTH=4, WIDTH=32, ERR_W=16).
module tb_count_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cnt_valid;
  logic [31:0] cnt;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_expected;
  logic [31:0] evt_actual;
  logic [1:0]  state;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;
  logic saw_evt;

  always #5 clk = ~clk;

  count_monitor #(
    .WIDTH      (32),
    .END_COUNT  (99),
    .FIFO_DEPTH (4),
    .ERR_W      (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cnt_valid_i    (cnt_valid),
    .cnt_i          (cnt),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (evt_ready),
    .evt_expected_o (evt_expected),
    .evt_actual_o   (evt_actual),
    .state_o        (state),
    .done_o         (done),
    .pass_o         (pass),
    .err_count_o    (err_count),
    .drop_count_o   (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, clock it, and settle just after the edge.
  task automatic cyc(input logic v, input logic [31:0] c);
    cnt_valid = v;
    cnt       = c;
    @(posedge clk);
    #1;
    if (evt_valid) saw_evt = 1'b1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) cyc(1'b1, 32'(i));
  endtask

  task automatic chk_evt(input string tag, input logic [31:0] e, input logic [31:0] a);
    chk({tag, "_valid"}, 64'(evt_valid), 64'd1);
    chk({tag, "_exp"}, 64'(evt_expected), 64'(e));
    chk({tag, "_act"}, 64'(evt_actual), 64'(a));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
    chk({tag, "_drop"}, 64'(drop_count), 64'd0);
    chk({tag, "_evt_valid"}, 64'(evt_valid), 64'd0);
    chk({tag, "_evt_exp"}, 64'(evt_expected), 64'd0);
    chk({tag, "_evt_act"}, 64'(evt_actual), 64'd0);
  endtask

  task automatic do_reset(input int n, input string tag);
    reset_n   = 1'b0;
    cnt_valid = 1'b0;
    cnt       = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk_zero(tag);
    reset_n = 1'b1;
    saw_evt = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cnt_valid = 1'b0;
    cnt       = '0;
    evt_ready = 1'b0;
    saw_evt   = 1'b0;

    // Clean run 0..99
    do_reset(2, "rst0");
    run(0, 98);
    chk("clean_state_mid", 64'(state), 64'd1);
    chk("clean_done_mid", 64'(done), 64'd0);
    cyc(1'b1, 32'd99);
    chk("clean_state", 64'(state), 64'd2);
    chk("clean_done", 64'(done), 64'd1);
    chk("clean_pass", 64'(pass), 64'd1);
    chk("clean_err", 64'(err_count), 64'd0);
    chk("clean_no_evt", 64'(saw_evt), 64'd0);

    // Skip 10: one event {10,11}, held while not ready
    do_reset(1, "rst1");
    run(0, 9);
    cyc(1'b1, 32'd11);
    chk_evt("skip_evt", 32'd10, 32'd11);
    chk("skip_err", 64'(err_count), 64'd1);
    run(12, 99);
    chk("skip_err_end", 64'(err_count), 64'd1);
    chk("skip_done", 64'(done), 64'd1);
    chk("skip_pass", 64'(pass), 64'd0);
    chk("skip_drop", 64'(drop_count), 64'd0);
    chk_evt("skip_held", 32'd10, 32'd11);
    evt_ready = 1'b1;
    cyc(1'b1, 32'd7);
    chk("skip_drained_in_done", 64'(evt_valid), 64'd0);
    chk("skip_err_after_done", 64'(err_count), 64'd1);
    evt_ready = 1'b0;

    // Bad start at 5; event stays pending and is discarded by reset
    do_reset(1, "rst2");
    cyc(1'b1, 32'd5);
    chk("bad_state", 64'(state), 64'd1);
    chk_evt("bad_evt", 32'd0, 32'd5);
    chk("bad_err", 64'(err_count), 64'd1);
    run(6, 99);
    chk("bad_err_end", 64'(err_count), 64'd1);
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_pass", 64'(pass), 64'd0);

    // Overflow: six mismatches into a 4-deep buffer with no consumer
    do_reset(1, "rst3");
    cyc(1'b1, 32'd0);
    for (int k = 1; k <= 6; k++) cyc(1'b1, 32'(2 * k));
    chk("ovf_err", 64'(err_count), 64'd6);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk_evt("ovf_head", 32'd1, 32'd2);
    // Push while full with a pop: {13,20} accepted, no new drop
    evt_ready = 1'b1;
    cyc(1'b1, 32'd20);
    chk("ovf_err_pp", 64'(err_count), 64'd7);
    chk("ovf_drop_pp", 64'(drop_count), 64'd2);
    chk_evt("drain1", 32'd3, 32'd4);
    cyc(1'b1, 32'd21);
    chk_evt("drain2", 32'd5, 32'd6);
    cyc(1'b1, 32'd22);
    chk_evt("drain3", 32'd7, 32'd8);
    cyc(1'b1, 32'd23);
    chk_evt("drain4", 32'd13, 32'd20);
    cyc(1'b1, 32'd24);
    chk("drain_empty", 64'(evt_valid), 64'd0);
    chk("drain_err", 64'(err_count), 64'd7);

    // Upstream reset at count 50
    do_reset(1, "rst4");
    run(0, 50);
    chk("ups_track", 64'(state), 64'd1);
    cyc(1'b0, 32'd0);
    chk("ups_idle", 64'(state), 64'd0);
    chk("ups_err_idle", 64'(err_count), 64'd0);
    cyc(1'b1, 32'd0);
    chk("ups_track2", 64'(state), 64'd1);
    run(1, 99);
    chk("ups_done", 64'(done), 64'd1);
    chk("ups_pass", 64'(pass), 64'd1);
    chk("ups_err", 64'(err_count), 64'd0);
    chk("ups_no_evt", 64'(saw_evt), 64'd0);

    // Wrap: start at FFFFFFFE, all-ones -> 0 is a match
    do_reset(1, "rst5");
    evt_ready = 1'b0;
    cyc(1'b1, 32'hFFFF_FFFE);
    chk_evt("wrap_evt", 32'd0, 32'hFFFF_FFFE);
    cyc(1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 32'd0);
    chk("wrap_err", 64'(err_count), 64'd1);
    run(1, 99);
    chk("wrap_err_end", 64'(err_count), 64'd1);
    chk("wrap_done", 64'(done), 64'd1);
    // DONE ignores further samples
    cyc(1'b1, 32'd1234);
    cyc(1'b1, 32'hDEAD_BEEF);
    cyc(1'b0, 32'd0);
    chk("hold_state", 64'(state), 64'd2);
    chk("hold_err", 64'(err_count), 64'd1);
    chk("hold_drop", 64'(drop_count), 64'd0);
    chk_evt("hold_evt", 32'd0, 32'hFFFF_FFFE);
    do_reset(1, "rst_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream checker for the free-running cycle counter. It samples the counter value each cycle and checks that it starts at 0 and increments by exactly 1 until a configured end count. Each mismatch is logged as an {expected, actual} event into a small buffered stream for the testbench or coverage collector. It also reports pass/done status once the run completes.

## Interface
Parameters:
- WIDTH, 32, counter width
- END_COUNT, 99, final counter value that ends the run
- FIFO_DEPTH, 4, event buffer entries; must be a power of 2, ≥2
- ERR_W, 16, error counter width

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- cnt_valid_i  in  1  high while the upstream counter is out of reset
- cnt_i  in  WIDTH  upstream counter value
- evt_valid_o  out  1  event available at FIFO head
- evt_ready_i  in  1  consumer accepts the head event
- evt_expected_o  out  WIDTH  expected value of the head event
- evt_actual_o  out  WIDTH  observed value of the head event
- state_o  out  2  FSM state: IDLE=0, TRACK=1, DONE=2
- done_o  out  1  run complete
- pass_o  out  1  done with zero errors; valid only while done_o=1
- err_count_o  out  ERR_W  mismatches seen; saturates at all-ones
- drop_count_o  out  8  events lost to a full FIFO; saturates at 255

## Operation
- Reset (reset_n=0 at posedge): state=IDLE, internal expected=0, FIFO empty. All outputs are 0.
- IDLE:
  - Wait for cnt_valid_i=1.
  - On the first valid sample, compare cnt_i against 0.
  - Load expected ← cnt_i+1. This resyncs to the observed value, so a bad start produces one error, not a cascade.
  - Go to TRACK. If cnt_i==END_COUNT, go to DONE instead.
- TRACK:
  - Each cycle with cnt_valid_i=1, compare cnt_i to expected.
  - On mismatch, push {expected, cnt_i}, increment err_count, and set expected ← cnt_i+1.
  - On match, set expected ← expected+1.
  - When cnt_i==END_COUNT, go to DONE. The comparison is still performed on that sample.
  - cnt_valid_i=0 means upstream reset mid-run: go to IDLE, with no error.
- DONE:
  - Terminal state. Samples are ignored; only reset_n exits.
  - done_o=1; pass_o=(err_count==0 && drop_count==0).
- Arithmetic: expected+1 wraps modulo 2^WIDTH, so all-ones followed by 0 is a match.
- FIFO behaviour:
  - Registered, first-word-fall-through head. Pop when evt_valid_o && evt_ready_i.
  - Push while full without a simultaneous pop: the event is dropped and drop_count increments. err_count still increments.
  - Push while full with a simultaneous pop: accepted; occupancy stays full.
  - Push and pop together when occupancy is between 1 and FIFO_DEPTH-1: both happen.
  - Push while empty: no bypass; the event appears the next cycle.
  - The FIFO keeps draining in DONE.

## Timing
- Sample at posedge N with a mismatch:
  - evt_valid_o=1 and err_count_o updated after edge N, visible in cycle N+1.
- state_o and done_o update after the edge that samples END_COUNT.
- pass_o is valid in the same cycle done_o rises.
- evt_* outputs are held stable while evt_valid_o=1 && evt_ready_i=0.
- A pop at edge M exposes the next entry, or deasserts evt_valid_o, in cycle M+1.
- reset_n low mid-run: takes effect at the next edge; pending events are discarded.
- No combinational path from cnt_i or evt_ready_i to any output.

## Structure
- count_mon_pkg holds:
  - state_e enum (IDLE/TRACK/DONE, 2 bits)
  - evt_t packed struct {expected, actual}, sized by a package WIDTH constant shared with the upstream counter
- Sub-module count_mon_fifo: parameterised FIFO_DEPTH × evt_t buffer.
  - Push/full, pop/empty, with pointer wrap and an occupancy counter.
  - Reports drop on push-while-full without pop.
- Top level holds the FSM, the expected register and the saturating counters.

## Test plan
- Clean run:
  - Stimulus: reset_n=0 for 2 cycles; cnt_valid_i=1; cnt_i=0..99.
  - Response: done_o rises the cycle after the 99 sample; pass_o=1; err_count_o=0; evt_valid_o never asserts.
- Skip:
  - Stimulus: 0..9, then 11, 12..99.
  - Response: exactly one event {10,11}; err_count_o=1; no follow-on errors; pass_o=0 at done.
- Bad start:
  - Stimulus: first valid sample 5, then 6, 7…
  - Response: event {0,5}; err_count_o=1; tracking continues cleanly.
- FIFO overflow:
  - Stimulus: evt_ready_i=0; inject 6 mismatches; then set evt_ready_i=1.
  - Response: 4 events held, drop_count_o=2, err_count_o=6. Events then drain in injection order, one per cycle.
- Upstream reset mid-run:
  - Stimulus: cnt_valid_i drops at count 50; returns with cnt_i restarting at 0.
  - Response: state_o goes 1→0→1; no error; done at 99.
- Wrap and DONE hold:
  - Stimulus: END_COUNT=3, cnt_i starting at 0xFFFFFFFE: FFFFFFFE, FFFFFFFF, 0, 1, 2, 3.
  - Response: one start error only; the FFFFFFFF→0 transition is not an error.
  - Stimulus: after DONE, drive arbitrary cnt_i.
  - Response: counters unchanged.
  - Stimulus: reset_n=0.
  - Response: all outputs return to 0.
